// File: rtl/vdot_pkg.sv
// Shared types and constants for the VDOT dot-product unit.
package vdot_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } vdot_state_e;

    localparam int unsigned ACC_W  = 36;
    localparam int unsigned PROD_W = 32;

    localparam logic signed [ACC_W-1:0] S16_MAX = 36'sd32767;
    localparam logic signed [ACC_W-1:0] S16_MIN = -36'sd32768;

endpackage

// File: rtl/vdot_if.sv
// Start/done level handshake plus operand and result buses of the VDOT unit.
interface vdot_if #(
    parameter int unsigned N_ELEM = 16,
    parameter int unsigned W      = 16
);

    logic                start;
    logic [N_ELEM*W-1:0] Inval1;
    logic [N_ELEM*W-1:0] Inval2;
    logic [W-1:0]        DotOut;
    logic                Overflw;
    logic                done;

    modport master (
        output start,
        output Inval1,
        output Inval2,
        input  DotOut,
        input  Overflw,
        input  done
    );

    modport slave (
        input  start,
        input  Inval1,
        input  Inval2,
        output DotOut,
        output Overflw,
        output done
    );

endinterface

// File: rtl/vdot_mac.sv
// Registered signed multiply feeding a 36-bit accumulator.
module vdot_mac
    import vdot_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    valid_i,
    input  logic signed [W-1:0]     a_i,
    input  logic signed [W-1:0]     b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     pv_q, pv_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        prod_d = prod_q;
        pv_d   = valid_i;
        acc_d  = acc_q;
        if (valid_i) begin
            prod_d = PROD_W'(a_i) * PROD_W'(b_i);
        end
        if (clear_i) begin
            pv_d  = 1'b0;
            acc_d = '0;
        end else if (pv_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
    end

    // Exposes the sum including the product in flight so the drain cycle sees the full total.
    assign acc_o = acc_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            pv_q   <= pv_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/vdot_unit.sv
// Sequential 16-element signed dot product for VDOT; define VDOT_SAT_EN to saturate
// DotOut on overflow instead of wrapping.
module vdot_unit
    import vdot_pkg::*;
#(
    parameter int unsigned N_ELEM = 16,
    parameter int unsigned W      = 16,
    parameter int unsigned FRAC   = 0
) (
    input logic   Clk1,
    input logic   Reset,
    vdot_if.slave bus
);

    localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int unsigned VEC_W = N_ELEM * W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    vdot_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] op_a_q, op_a_d;
    logic [VEC_W-1:0] op_b_q, op_b_d;
    logic [W-1:0]     dot_q, dot_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic                    mac_clear;
    logic                    mac_valid;
    logic signed [W-1:0]     elem_a [N_ELEM];
    logic signed [W-1:0]     elem_b [N_ELEM];
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] s;
    logic                    ovf_now;
    logic [W-1:0]            res;

    for (genvar i = 0; i < N_ELEM; i++) begin : g_elem
        assign elem_a[i] = op_a_q[i*W +: W];
        assign elem_b[i] = op_b_q[i*W +: W];
    end

    vdot_mac #(
        .W (W)
    ) u_mac (
        .clk_i   (Clk1),
        .rst_i   (Reset),
        .clear_i (mac_clear),
        .valid_i (mac_valid),
        .a_i     (elem_a[idx_q]),
        .b_i     (elem_b[idx_q]),
        .acc_o   (acc)
    );

    assign s       = acc >>> FRAC;
    assign ovf_now = (s > S16_MAX) || (s < S16_MIN);

    always_comb begin
`ifdef VDOT_SAT_EN
        if (ovf_now) begin
            res = s[ACC_W-1] ? SAT_NEG : SAT_POS;
        end else begin
            res = s[W-1:0];
        end
`else
        res = s[W-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        dot_d     = dot_q;
        ovf_d     = ovf_q;
        done_d    = done_q;
        mac_clear = 1'b0;
        mac_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (bus.start) begin
                    op_a_d    = bus.Inval1;
                    op_b_d    = bus.Inval2;
                    idx_d     = '0;
                    mac_clear = 1'b1;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (!bus.start) begin
                    state_d = StIdle;
                end else begin
                    mac_valid = 1'b1;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!bus.start) begin
                    state_d = StIdle;
                end else begin
                    dot_d   = res;
                    ovf_d   = ovf_now;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!bus.start) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            dot_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            dot_q   <= dot_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.DotOut  = dot_q;
    assign bus.Overflw = ovf_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_vdot_unit.sv
// Directed scoreboard bench for vdot_unit: one instance with FRAC=0 and one with FRAC=8.
module tb_vdot_unit;

    localparam int N = 16;
    localparam int W = 16;

    typedef struct {
        logic [15:0] dot;
        logic        ovf;
        string       tag;
    } exp_t;

    logic Clk1  = 1'b0;
    logic Reset = 1'b1;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 Clk1 = ~Clk1;

    vdot_if #(.N_ELEM(N), .W(W)) bus0 ();
    vdot_if #(.N_ELEM(N), .W(W)) bus8 ();

    vdot_unit #(.N_ELEM(N), .W(W), .FRAC(0)) u_dut0 (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus0)
    );

    vdot_unit #(.N_ELEM(N), .W(W), .FRAC(8)) u_dut8 (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus8)
    );

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [255:0] a,
                         input logic [255:0] b);
        if (sel == 0) begin
            bus0.start = st;  bus0.Inval1 = a;  bus0.Inval2 = b;
        end else begin
            bus8.start = st;  bus8.Inval1 = a;  bus8.Inval2 = b;
        end
    endtask

    // {done, Overflw, DotOut}
    function automatic logic [17:0] outs(input int sel);
        if (sel == 0) return {bus0.done, bus0.Overflw, bus0.DotOut};
        return {bus8.done, bus8.Overflw, bus8.DotOut};
    endfunction

    function automatic logic [255:0] splat(input logic [15:0] v);
        logic [255:0] r;
        for (int i = 0; i < N; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    task automatic run_op(input int sel, input logic [255:0] a, input logic [255:0] b,
                          input logic [15:0] edot, input logic eovf, input string tag);
        exp_t        e;
        int          n;
        logic        got;
        logic [17:0] o;
        sb.push_back('{edot, eovf, tag});
        drive(sel, 1'b1, a, b);
        n   = 0;
        got = 1'b0;
        o   = '0;
        while (!got && n < 60) begin
            @(negedge Clk1);
            n++;
            // Operands are already latched; scrambling them must not change the result.
            if (n == 1) drive(sel, 1'b1, ~a, ~b);
            o = outs(sel);
            if (o[17]) got = 1'b1;
        end
        e = sb.pop_front();
        check({e.tag, " done_seen"}, 36'(got), 36'd1);
        if (got) begin
            check({e.tag, " latency"}, 36'(n - 1), 36'd17);
            check({e.tag, " dot"}, 36'(o[15:0]), 36'(e.dot));
            check({e.tag, " ovf"}, 36'(o[16]), 36'(e.ovf));
            repeat (2) @(negedge Clk1);
            o = outs(sel);
            check({e.tag, " hold"}, 36'(o), 36'({1'b1, e.ovf, e.dot}));
        end
        drive(sel, 1'b0, '0, '0);
        @(negedge Clk1);
        o = outs(sel);
        check({e.tag, " release"}, 36'(o), 36'({1'b0, e.ovf, e.dot}));
        @(negedge Clk1);
    endtask

    initial begin
        logic [255:0] ramp;
        logic [255:0] va;
        logic [15:0]  exp_max, exp_neg, exp_p1;
        logic         saw;
        logic [17:0]  o;

`ifdef VDOT_SAT_EN
        exp_max = 16'h7FFF;  exp_neg = 16'h8000;  exp_p1 = 16'h7FFF;
`else
        exp_max = 16'h0010;  exp_neg = 16'h0000;  exp_p1 = 16'h8000;
`endif
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        repeat (2) @(negedge Clk1);
        check("reset_dut0", 36'(outs(0)), 36'd0);
        check("reset_dut8", 36'(outs(1)), 36'd0);
        Reset = 1'b0;
        @(negedge Clk1);

        run_op(0, splat(16'd1), splat(16'd2), 16'h0020, 1'b0, "a1_b2");

        for (int i = 0; i < N; i++) ramp[i*16 +: 16] = 16'(i);
        run_op(0, ramp, splat(16'hFFFF), 16'hFF88, 1'b0, "ramp_neg1");

        run_op(1, splat(16'h0100), splat(16'h0100), 16'h1000, 1'b0, "frac8_one");

        run_op(0, splat(16'h7FFF), splat(16'h7FFF), exp_max, 1'b1, "max_pos");
        run_op(0, splat(16'h7FFF), splat(16'h8000), exp_neg, 1'b1, "max_neg");

        va = '0;  va[15:0] = 16'h7FFF;
        run_op(0, va, splat(16'd1), 16'h7FFF, 1'b0, "edge_32767");
        va[31:16] = 16'd1;
        run_op(0, va, splat(16'd1), exp_p1, 1'b1, "edge_32768");
        va = '0;  va[15:0] = 16'h8000;
        run_op(0, va, splat(16'd1), 16'h8000, 1'b0, "edge_m32768");

        // Abort before edge 8: no done, outputs keep the last result.
        drive(0, 1'b1, splat(16'd3), splat(16'd3));
        repeat (8) @(negedge Clk1);
        drive(0, 1'b0, '0, '0);
        saw = 1'b0;
        repeat (30) begin
            @(negedge Clk1);
            if (outs(0) & 18'h20000) saw = 1'b1;
        end
        check("abort_no_done", 36'(saw), 36'd0);
        check("abort_hold", 36'(outs(0)), 36'({1'b0, 1'b0, 16'h8000}));
        run_op(0, splat(16'd1), splat(16'd1), 16'h0010, 1'b0, "after_abort");

        // Reset at edge 10 of an operation clears outputs immediately.
        drive(0, 1'b1, splat(16'd5), splat(16'd5));
        repeat (10) @(negedge Clk1);
        @(posedge Clk1);
        Reset = 1'b1;
        #1;
        o = outs(0);
        check("midop_reset_dut0", 36'(o), 36'd0);
        check("midop_reset_dut8", 36'(outs(1)), 36'd0);
        drive(0, 1'b0, '0, '0);
        @(negedge Clk1);
        Reset = 1'b0;
        @(negedge Clk1);
        run_op(0, splat(16'd1), splat(16'd2), 16'h0020, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
